// File: rtl/program_sequencer_stk.sv
// Program sequencer with a hardware call/return stack and a hold input.
// pm_addr is the combinational next program counter; pc follows it every edge.
module program_sequencer_stk #(
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_W     = 3
) (
    input  logic               clk,
    input  logic               sync_reset,
    input  logic               jmp,
    input  logic               jmp_nz,
    input  logic               dont_jmp,
    input  logic               call,
    input  logic               ret,
    input  logic [3:0]         jmp_addr,
    input  logic               hold,
    output logic [7:0]         pm_addr,
    output logic [7:0]         pc,
    output logic [7:0]         from_PS,
    output logic [DEPTH_W-1:0] stack_depth,
    output logic               stack_overflow,
    output logic               stack_underflow
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] FULL_C = DEPTH_W'(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0] ONE_C  = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] ZERO_C = DEPTH_W'(0);

    logic [7:0]         pc_q, pc_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic [7:0]         stack_q [STACK_DEPTH];

    logic [7:0]         pc_inc_s;
    logic [7:0]         target_s;
    logic               push_s;
    logic [IDX_W-1:0]   push_idx_s;
    logic [IDX_W-1:0]   top_idx_s;

    // pc+1 wraps naturally at 8 bits; jump/call targets sit on 16-byte boundaries
    assign pc_inc_s   = pc_q + 8'd1;
    assign target_s   = {jmp_addr, 4'h0};
    assign push_idx_s = IDX_W'(depth_q);
    assign top_idx_s  = IDX_W'(depth_q - ONE_C);

    // Next-pc selection in priority order, plus stack/flag side effects
    always_comb begin
        pc_d    = pc_inc_s;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_s  = 1'b0;
        if (sync_reset) begin
            pc_d    = 8'h00;
            depth_d = ZERO_C;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (hold) begin
            pc_d = pc_q;
        end else if (jmp) begin
            pc_d = target_s;
        end else if (jmp_nz) begin
            if (!dont_jmp) begin
                pc_d = target_s;
            end else begin
                pc_d = pc_inc_s;
            end
        end else if (call) begin
            // The jump is taken even when the stack is full; only the push is lost
            pc_d = target_s;
            if (depth_q < FULL_C) begin
                push_s  = 1'b1;
                depth_d = depth_q + ONE_C;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (ret) begin
            if (depth_q != ZERO_C) begin
                pc_d    = stack_q[top_idx_s];
                depth_d = depth_q - ONE_C;
            end else begin
                pc_d  = pc_inc_s;
                unf_d = 1'b1;
            end
        end else begin
            pc_d = pc_inc_s;
        end
    end

    // Program counter, depth counter and sticky flags
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pc_q    <= 8'h00;
            depth_q <= ZERO_C;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-address storage; contents need no reset because depth gates every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            stack_q[push_idx_s] <= pc_inc_s;
        end
    end

    assign pm_addr         = pc_d;
    assign pc              = pc_q;
    assign from_PS         = pc_q;
    assign stack_depth     = depth_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_program_sequencer_stk.sv
// Self-checking bench: directed vector table, wrap sequence, then random
// stimulus checked against a queue-based reference model.
module tb_program_sequencer_stk;

    localparam int STACK_DEPTH = 4;
    localparam int DEPTH_W     = 3;

    logic       clk = 1'b0;
    logic       sync_reset = 1'b0, jmp = 1'b0, jmp_nz = 1'b0, dont_jmp = 1'b0;
    logic       call = 1'b0, ret = 1'b0, hold = 1'b0;
    logic [3:0] jmp_addr = 4'h0;
    logic [7:0] pm_addr, pc, from_PS;
    logic [DEPTH_W-1:0] stack_depth;
    logic       stack_overflow, stack_underflow;

    int pass_cnt = 0;
    int total_cnt = 0;

    program_sequencer_stk #(.STACK_DEPTH(STACK_DEPTH), .DEPTH_W(DEPTH_W)) dut (
        .clk(clk), .sync_reset(sync_reset), .jmp(jmp), .jmp_nz(jmp_nz),
        .dont_jmp(dont_jmp), .call(call), .ret(ret), .jmp_addr(jmp_addr),
        .hold(hold), .pm_addr(pm_addr), .pc(pc), .from_PS(from_PS),
        .stack_depth(stack_depth), .stack_overflow(stack_overflow),
        .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    // control word: {rst, hold, jmp, jmp_nz, dont_jmp, call, ret}
    localparam bit [6:0] NON = 7'b0000000;
    localparam bit [6:0] RST = 7'b1000000;
    localparam bit [6:0] HLD = 7'b0100000;
    localparam bit [6:0] JMP = 7'b0010000;
    localparam bit [6:0] JNZ = 7'b0001000;
    localparam bit [6:0] DJ  = 7'b0000100;
    localparam bit [6:0] CAL = 7'b0000010;
    localparam bit [6:0] RET = 7'b0000001;

    typedef struct {
        bit [6:0] ctl;
        bit [3:0] a;
        bit [7:0] pm;
        bit [2:0] depth;
        bit       ovf;
        bit       unf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit [6:0] ctl, bit [3:0] a, bit [7:0] pm,
                                bit [2:0] depth, bit ovf, bit unf);
        vec_t v;
        v.ctl = ctl; v.a = a; v.pm = pm; v.depth = depth; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Drive one cycle of inputs, check pm_addr before the edge and state after it
    task automatic apply(bit [6:0] ctl, bit [3:0] a, bit [7:0] exp_pm,
                         bit [2:0] exp_depth, bit exp_ovf, bit exp_unf);
        @(negedge clk);
        {sync_reset, hold, jmp, jmp_nz, dont_jmp, call, ret} = ctl;
        jmp_addr = a;
        #1;
        chk("pm_addr", int'(pm_addr), int'(exp_pm));
        @(posedge clk);
        #1;
        chk("pc", int'(pc), int'(exp_pm));
        chk("from_PS", int'(from_PS), int'(exp_pm));
        chk("stack_depth", int'(stack_depth), int'(exp_depth));
        chk("stack_overflow", int'(stack_overflow), int'(exp_ovf));
        chk("stack_underflow", int'(stack_underflow), int'(exp_unf));
    endtask

    // Reference model: pc as an integer, stack as a queue of return addresses
    int m_pc = 0;
    int m_stack[$];
    bit m_ovf = 1'b0, m_unf = 1'b0;

    function automatic int model_pm(bit [6:0] ctl, bit [3:0] a);
        int nxt = (m_pc + 1) % 256;
        int tgt = int'(a) * 16;
        if (ctl[6]) return 0;
        if (ctl[5]) return m_pc;
        if (ctl[4]) return tgt;
        if (ctl[3]) return ctl[2] ? nxt : tgt;
        if (ctl[1]) return tgt;
        if (ctl[0]) return (m_stack.size() > 0) ? m_stack[$] : nxt;
        return nxt;
    endfunction

    function automatic void model_step(bit [6:0] ctl, bit [3:0] a);
        int pm = model_pm(ctl, a);
        if (ctl[6]) begin
            m_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (!ctl[5] && !ctl[4] && !ctl[3]) begin
            if (ctl[1]) begin
                if (m_stack.size() < STACK_DEPTH) m_stack.push_back((m_pc + 1) % 256);
                else m_ovf = 1'b1;
            end else if (ctl[0]) begin
                if (m_stack.size() > 0) void'(m_stack.pop_back());
                else m_unf = 1'b1;
            end
        end
        m_pc = pm;
    endfunction

    task automatic apply_model(bit [6:0] ctl, bit [3:0] a);
        bit [7:0] epm = 8'(model_pm(ctl, a));
        model_step(ctl, a);
        apply(ctl, a, epm, 3'(m_stack.size()), m_ovf, m_unf);
    endtask

    initial begin
        // reset, conditional jumps
        tbl.push_back(mk(RST,       4'h0, 8'h00, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(JMP,       4'h1, 8'h10, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(NON,       4'h0, 8'h11, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(NON,       4'h0, 8'h12, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(JNZ,       4'h3, 8'h30, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(JMP,       4'h1, 8'h10, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(NON,       4'h0, 8'h11, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(NON,       4'h0, 8'h12, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(JNZ | DJ,  4'h3, 8'h13, 3'd0, 1'b0, 1'b0));
        // nested calls from pc=05
        tbl.push_back(mk(RST,       4'h7, 8'h00, 3'd0, 1'b0, 1'b0));
        for (int i = 1; i <= 5; i++) tbl.push_back(mk(NON, 4'h0, 8'(i), 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(CAL,       4'h4, 8'h40, 3'd1, 1'b0, 1'b0));
        tbl.push_back(mk(NON,       4'h0, 8'h41, 3'd1, 1'b0, 1'b0));
        tbl.push_back(mk(CAL,       4'h8, 8'h80, 3'd2, 1'b0, 1'b0));
        tbl.push_back(mk(RET,       4'h0, 8'h42, 3'd1, 1'b0, 1'b0));
        tbl.push_back(mk(RET,       4'h0, 8'h06, 3'd0, 1'b0, 1'b0));
        // overflow: five calls, pushes 07,11,21,31 then discard
        tbl.push_back(mk(CAL,       4'h1, 8'h10, 3'd1, 1'b0, 1'b0));
        tbl.push_back(mk(CAL,       4'h2, 8'h20, 3'd2, 1'b0, 1'b0));
        tbl.push_back(mk(CAL,       4'h3, 8'h30, 3'd3, 1'b0, 1'b0));
        tbl.push_back(mk(CAL,       4'h4, 8'h40, 3'd4, 1'b0, 1'b0));
        tbl.push_back(mk(CAL,       4'h5, 8'h50, 3'd4, 1'b1, 1'b0));
        // LIFO returns, then underflow
        tbl.push_back(mk(RET,       4'h0, 8'h31, 3'd3, 1'b1, 1'b0));
        tbl.push_back(mk(RET,       4'h0, 8'h21, 3'd2, 1'b1, 1'b0));
        tbl.push_back(mk(RET,       4'h0, 8'h11, 3'd1, 1'b1, 1'b0));
        tbl.push_back(mk(RET,       4'h0, 8'h07, 3'd0, 1'b1, 1'b0));
        tbl.push_back(mk(RET,       4'h0, 8'h08, 3'd0, 1'b1, 1'b1));
        // hold masks call; jmp masks call
        for (int i = 0; i < 3; i++) tbl.push_back(mk(HLD | CAL, 4'h9, 8'h08, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk(JMP | CAL, 4'hA, 8'hA0, 3'd0, 1'b1, 1'b1));
        // reset mid-operation at depth 3 with both flags set
        tbl.push_back(mk(CAL,       4'h1, 8'h10, 3'd1, 1'b1, 1'b1));
        tbl.push_back(mk(CAL,       4'h2, 8'h20, 3'd2, 1'b1, 1'b1));
        tbl.push_back(mk(CAL,       4'h3, 8'h30, 3'd3, 1'b1, 1'b1));
        tbl.push_back(mk(RST | RET, 4'h0, 8'h00, 3'd0, 1'b0, 1'b0));
        // hold with a non-empty stack, then return through it
        tbl.push_back(mk(CAL,       4'h6, 8'h60, 3'd1, 1'b0, 1'b0));
        tbl.push_back(mk(HLD | RET, 4'h0, 8'h60, 3'd1, 1'b0, 1'b0));
        tbl.push_back(mk(JNZ | RET, 4'h2, 8'h20, 3'd1, 1'b0, 1'b0));
        tbl.push_back(mk(RET,       4'h0, 8'h01, 3'd0, 1'b0, 1'b0));

        foreach (tbl[i]) apply(tbl[i].ctl, tbl[i].a, tbl[i].pm, tbl[i].depth, tbl[i].ovf, tbl[i].unf);

        // free-run wrap: F0 .. FF then 00
        apply(JMP, 4'hF, 8'hF0, 3'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) apply(NON, 4'h0, 8'(8'hF0 + i), 3'd0, 1'b0, 1'b0);

        // randomized stimulus against the reference model
        apply_model(RST, 4'h0);
        for (int n = 0; n < 600; n++) begin
            bit [6:0] c;
            c[6] = ($urandom_range(0, 63) == 0);
            c[5] = ($urandom_range(0, 7) == 0);
            c[4] = ($urandom_range(0, 9) == 0);
            c[3] = ($urandom_range(0, 7) == 0);
            c[2] = 1'($urandom_range(0, 1));
            c[1] = ($urandom_range(0, 2) == 0);
            c[0] = ($urandom_range(0, 2) == 0);
            apply_model(c, 4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/program_sequencer_stk.md
Name: program_sequencer_stk

Overview:
- Program sequencer for the 8-bit microprocessor; drives the program-memory address each cycle.
- Holds the program counter and resolves jmp / jmp_nz from the instruction decoder.
- Adds a hardware call/return stack and a hold (freeze) input for single-stepping or external stall.
- pm_addr feeds the program memory; the fetched word returns to the decoder as next_instr.

Parameters:
- STACK_DEPTH, 4, number of return-address entries (1..8).
- DEPTH_W, 3, width of stack_depth output; must hold values 0..STACK_DEPTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- sync_reset  input  1  synchronous, active-high reset
- jmp  input  1  unconditional jump, from decoder
- jmp_nz  input  1  conditional jump, taken when dont_jmp=0
- dont_jmp  input  1  ALU zero flag; 1 suppresses jmp_nz
- call  input  1  jump to subroutine and push return address
- ret  input  1  return from subroutine, pop address
- jmp_addr  input  4  ir_nibble; jump/call target is {jmp_addr,4'h0}
- hold  input  1  freeze pc, stack and flags
- pm_addr  output  8  program-memory address (combinational)
- pc  output  8  registered program counter
- from_PS  output  8  debug tap, equals pc
- stack_depth  output  DEPTH_W  current number of stacked entries
- stack_overflow  output  1  sticky; call issued while stack full
- stack_underflow  output  1  sticky; ret issued while stack empty

Behaviour:
- Every clock edge: pc <= pm_addr. Fetch latency: pm_addr is presented combinationally in the same cycle; the instruction appears at the decoder's ir one edge later.
- pm_addr priority, highest first:
  - sync_reset: 8'h00
  - hold: pc
  - jmp: {jmp_addr,4'h0}
  - jmp_nz & !dont_jmp: {jmp_addr,4'h0}
  - jmp_nz & dont_jmp: pc+1
  - call: {jmp_addr,4'h0}
  - ret & depth>0: stack top
  - ret & depth=0: pc+1
  - otherwise: pc+1
- pc+1 is modulo 256 (8'hFF -> 8'h00); no flag is raised on wrap.
- Stack is a LIFO of 8-bit entries with a depth counter (0..STACK_DEPTH):
  - call with depth<STACK_DEPTH: push pc+1 (mod 256), depth+1.
  - call with depth=STACK_DEPTH: jump still taken, push discarded, depth unchanged, stack_overflow <= 1.
  - ret with depth>0: pm_addr = top entry, pop, depth-1.
  - ret with depth=0: no pop, stack_underflow <= 1.
  - A call or ret masked by a higher-priority input (hold, jmp, jmp_nz) does not modify the stack or flags.
- hold=1: pc, stack contents, depth and flags all unchanged; pm_addr=pc.
- sync_reset=1 (any cycle, including mid-call): next edge sets pc=0, depth=0, both flags=0. Stack entry contents are don't-care.
- Reset values after a sync_reset edge:
  - pc=0, from_PS=0, stack_depth=0, stack_overflow=0, stack_underflow=0.
  - pm_addr=0 while sync_reset is asserted.
- Flags are sticky and clear only on sync_reset.
- No state before the first reset is guaranteed.

Test Plan:
- Reset then free-run: sync_reset 1 cycle, no control inputs -> pm_addr 00,01,02,...; pc=FF followed by pc=00 on wrap.
- Conditional jump: pc=12, jmp_nz=1, jmp_addr=3, dont_jmp=0 -> pc=30. Repeat with dont_jmp=1 -> pc=13.
- Nested calls and returns:
  - pc=05, call, jmp_addr=4 -> pc=40, depth=1.
  - At pc=41, call, jmp_addr=8 -> pc=80, depth=2.
  - ret -> pc=42, depth=1; then ret -> pc=06, depth=0.
- Overflow and underflow:
  - 5 calls with STACK_DEPTH=4 -> depth holds at 4, stack_overflow=1 from the 5th call.
  - 4 rets return the first four return addresses in LIFO order.
  - A 5th ret gives pm_addr=pc+1 and stack_underflow=1.
- Hold and priority:
  - hold=1 for 3 cycles with call=1 -> pc, depth and flags frozen.
  - jmp=1 and call=1 together -> jump taken, depth unchanged.
- Reset mid-operation: depth=3 and overflow=1, assert sync_reset with ret=1 -> pc=00, depth=0, both flags=0.
